pipeline_control_unit: RTL

- Next-generation main control for the 5-stage MIPS pipeline: decodes the ID-stage opcode and carries the control bits through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles; flushes on a taken branch resolved in MEM; freezes on an external hold.
- Decodes ADDI and J in addition to R-type/LW/SW/BEQ, flags illegal opcodes, and counts stall cycles.
- Sits between the IF/ID register and the datapath pipeline registers, replacing the purely combinational decoder.

---
 rtl/pipeline_control_unit_pkg.sv | 43 ++++
 rtl/pipeline_control_unit_control_decoder.sv | 55 +++++
 rtl/pipeline_control_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, ALUOp codes and
// the per-stage control bundles.
package pipeline_control_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Nested so that each pipeline stage simply peels off the next sub-bundle.
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef struct packed {
    logic     branch;
    logic     memread;
    logic     memwrite;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    mem_ctrl_t  mem;
  } ex_ctrl_t;

  typedef struct packed {
    ex_ctrl_t ex;
    logic     jump;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipeline_control_unit_control_decoder.sv
// Combinational main-control decode table; shared with single-cycle builds.
module pipeline_control_unit_control_decoder
  import pipeline_control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CTRL_W-1:0]   ctrl,
  output logic                illegal
);

  ctrl_t c;

  // Opcode to control bundle; unknown opcodes decode to all-zero and flag illegal.
  always_comb begin
    c       = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        c.ex.regdst      = 1'b1;
        c.ex.aluop       = ALUOP_FUNCT;
        c.ex.mem.wb.regwrite = 1'b1;
      end
      OP_LW: begin
        c.ex.alusrc      = 1'b1;
        c.ex.aluop       = ALUOP_ADD;
        c.ex.mem.memread = 1'b1;
        c.ex.mem.wb.regwrite = 1'b1;
        c.ex.mem.wb.memtoreg = 1'b1;
      end
      OP_SW: begin
        c.ex.alusrc       = 1'b1;
        c.ex.aluop        = ALUOP_ADD;
        c.ex.mem.memwrite = 1'b1;
      end
      OP_BEQ: begin
        c.ex.aluop      = ALUOP_SUB;
        c.ex.mem.branch = 1'b1;
      end
      OP_ADDI: begin
        c.ex.alusrc      = 1'b1;
        c.ex.aluop       = ALUOP_ADD;
        c.ex.mem.wb.regwrite = 1'b1;
      end
      OP_J: begin
        c.jump = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    ctrl = c;
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipelined main control: ID decode, ID/EX - EX/MEM - MEM/WB control registers,
// load-use bubble insertion, branch flush, external hold and stall counting.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 16,
  parameter logic        LOAD_USE_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic [OPCODE_W-1:0]   opcode_id,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  input  logic                  branch_taken_mem,
  output logic                  jump_id,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  ex_regdst,
  output logic                  ex_alusrc,
  output logic [1:0]            ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  mem_branch,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      stall_count
);

  logic [CTRL_W-1:0]   dec_vec;
  ctrl_t               dec;
  logic                dec_illegal;
  logic                load_use;

  ex_ctrl_t            ex_q,      ex_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  mem_ctrl_t           mem_q,     mem_d;
  wb_ctrl_t            wb_q,      wb_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;

  pipeline_control_unit_control_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_decoder (
    .opcode  (opcode_id),
    .ctrl    (dec_vec),
    .illegal (dec_illegal)
  );

  assign dec = ctrl_t'(dec_vec);

  // Load in EX whose destination feeds the instruction currently in ID.
  always_comb begin
    load_use = LOAD_USE_EN && ex_q.mem.memread &&
               ((ex_rt_q == rs_id) || (ex_rt_q == rt_id));
  end

  // Next state of the stage registers: hold > flush > load-use > normal advance.
  // A stalled or flushed ID instruction never raises illegal_op; a stalled one
  // is re-decoded on the following cycle, keeping the pulse to one cycle.
  always_comb begin
    ex_d      = ex_q;
    ex_rt_d   = ex_rt_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (!hold) begin
      wb_d = mem_q.wb;
      if (branch_taken_mem) begin
        ex_d      = '0;
        ex_rt_d   = rt_id;
        mem_d     = '0;
        illegal_d = 1'b0;
      end else if (load_use) begin
        ex_d      = '0;
        ex_rt_d   = '0;
        mem_d     = ex_q.mem;
        illegal_d = 1'b0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        ex_d      = dec.ex;
        ex_rt_d   = rt_id;
        mem_d     = ex_q.mem;
        illegal_d = dec_illegal;
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q      <= '0;
      ex_rt_q   <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      ex_rt_q   <= ex_rt_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Front-end enables; reset forces the PC and IF/ID to keep moving.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (!reset) begin
      if (hold) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (branch_taken_mem) begin
        if_id_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end
    end
  end

  // Registered bundles fanned out to the datapath.
  always_comb begin
    jump_id      = dec.jump && !branch_taken_mem;
    ex_regdst    = ex_q.regdst;
    ex_alusrc    = ex_q.alusrc;
    ex_aluop     = ex_q.aluop;
    ex_rt        = ex_rt_q;
    mem_branch   = mem_q.branch;
    mem_memread  = mem_q.memread;
    mem_memwrite = mem_q.memwrite;
    wb_regwrite  = wb_q.regwrite;
    wb_memtoreg  = wb_q.memtoreg;
    illegal_op   = illegal_q;
    stall_count  = cnt_q;
  end

endmodule
